sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction requester (IF) and the data requester (MEM).
- Fixed priority: data wins over inst. Once a request is presented to memory, the grant is locked until it is accepted.
- Routes each response back to its owner using an in-order ownership FIFO.
- Sits between the pipeline stages and the unified memory or bridge, replacing the separate inst/data SRAM ports.

Parameters:
MAX_OUTSTANDING, 2, max accepted-but-unanswered transactions; legal range 1..8
ADDR_W, 32, address width
DATA_W, 32, data width; wstrb width is DATA_W/8

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  inst request valid; held stable until inst_addr_ok
inst_wr  in  1  1 = write
inst_size  in  2  0 = byte, 1 = half, 2 = word
inst_addr  in  ADDR_W  address
inst_wstrb  in  DATA_W/8  byte strobes
inst_wdata  in  DATA_W  write data
inst_addr_ok  out  1  inst request accepted this cycle
inst_data_ok  out  1  inst response this cycle
inst_rdata  out  DATA_W  inst read data
data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  same widths as inst_*  data requester
data_addr_ok, data_data_ok  out  1  data requester handshake
data_rdata  out  DATA_W  data read data
mem_req  out  1  request to memory
mem_wr  out  1  muxed from granted requester
mem_size  out  2  muxed from granted requester
mem_addr  out  ADDR_W  muxed from granted requester
mem_wstrb  out  DATA_W/8  muxed from granted requester
mem_wdata  out  DATA_W  muxed from granted requester
mem_addr_ok  in  1  memory accepts request
mem_data_ok  in  1  memory returns response (in order)
mem_rdata  in  DATA_W  memory read data
outstanding  out  4  current FIFO occupancy
proto_err  out  1  sticky: mem_data_ok received while FIFO empty

Behaviour:
- Reset (resetn = 0, async): state = IDLE, FIFO empty, outstanding = 0, proto_err = 0.
  - All *_addr_ok, *_data_ok and mem_req = 0; *_rdata = 0.
  - A reset mid-transaction drops all ownership entries; later mem_data_ok is treated as unexpected.
- full = (outstanding == MAX_OUTSTANDING).
- FSM has two states, IDLE and HOLD. grant_sel is 0 = inst, 1 = data.
  - IDLE: grant_sel = data_req ? 1 : 0 (combinational). mem_req = (data_req | inst_req) & ~full.
  - IDLE, mem_req & ~mem_addr_ok: latch grant_sel, go to HOLD.
  - HOLD: grant_sel = latched value. mem_req = granted requester's req & ~full. A newly raised data_req does not preempt an inst grant.
  - HOLD, accept: return to IDLE.
  - HOLD, granted req drops (protocol violation): return to IDLE, no push.
- mem_* payload is a zero-latency combinational mux of the granted requester's fields.
- accept = mem_req & mem_addr_ok.
  - inst_addr_ok = accept & ~grant_sel; data_addr_ok = accept & grant_sel.
  - Push grant_sel into the FIFO tail on accept.
- Response routing is combinational from the FIFO head.
  - On mem_data_ok with FIFO non-empty: the head owner gets *_data_ok = 1 and *_rdata = mem_rdata.
  - The other requester's data_ok = 0 and its rdata = 0.
  - Pop the head at clock edge.
- Simultaneous push and pop: occupancy unchanged. An accept in the same cycle as a pop is still blocked when full was true at cycle start (full is evaluated on registered occupancy).
- A response in the same cycle as its own accept is not allowed (memory latency is at least 1 cycle). Routing uses the pre-push head.
- mem_data_ok with FIFO empty: ignored, no data_ok pulses, proto_err set to 1 (sticky until reset).
- FIFO is circular, with read/write pointers wrapping modulo MAX_OUTSTANDING. outstanding counts 0..MAX_OUTSTANDING.
- Write transactions also occupy a FIFO slot and receive data_ok (rdata is don't-care but still driven per the rule above).

Test Plan:
1. Only inst_req=1, addr 0x1C000000, mem_addr_ok=1 → mem_addr = 0x1C000000, inst_addr_ok=1 same cycle. mem_data_ok=1 two cycles later with rdata 0x02800C0C → inst_data_ok=1, inst_rdata=0x02800C0C, data_data_ok=0.
2. inst_req and data_req (addr 0x100, wr=1, wstrb=0xF) both high in IDLE → mem_addr=0x100, data_addr_ok=1, inst_addr_ok=0. Next cycle inst is granted.
3. Inst granted and mem_addr_ok=0 for 3 cycles, data_req raised in cycle 2 → mem_addr stays inst's, no switch. After inst accepted, data granted next cycle.
4. MAX_OUTSTANDING=2: two accepts with no responses → outstanding=2, mem_req=0 despite pending req. One mem_data_ok → outstanding=1, mem_req reasserts next cycle.
5. Accepts in order data, inst, then two mem_data_ok with 0xAAAA0000 and 0xBBBB0000 → data_rdata=0xAAAA0000 first, then inst_rdata=0xBBBB0000. Includes one cycle with push and pop together; outstanding stays constant.
6. mem_data_ok with FIFO empty → proto_err=1, no *_data_ok. Assert resetn=0 mid-transaction with outstanding=1 → outstanding=0 and all outputs 0 immediately (async).

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like memory port between an instruction and a data requester.
// Data has fixed priority; responses are steered back through an in-order ownership FIFO.
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [3:0]          outstanding,
  output logic                proto_err
);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]                 state_reg, state_next;
  logic                       grant_lat_reg, grant_lat_next;
  logic [PTR_W-1:0]           rd_ptr_reg, wr_ptr_reg;
  logic [3:0]                 count_reg;
  logic                       proto_err_reg;
  logic [MAX_OUTSTANDING-1:0] owner_reg;
  logic [MAX_OUTSTANDING-1:0] slot_we;

  logic grant_sel, granted_req, full, fifo_empty, req_int;
  logic accept, pop, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Once a request has been shown to memory and refused, the owner is frozen in HOLD.
  always_comb begin
    grant_sel   = (state_reg == HOLD) ? grant_lat_reg : data_req;
    granted_req = grant_sel ? data_req : inst_req;
    full        = (count_reg == 4'(MAX_OUTSTANDING));
    fifo_empty  = (count_reg == 4'd0);
    req_int     = resetn & granted_req & ~full;
    accept      = req_int & mem_addr_ok;
    pop         = resetn & mem_data_ok & ~fifo_empty;
    head        = owner_reg[rd_ptr_reg];
  end

  always_comb begin
    state_next     = state_reg;
    grant_lat_next = grant_lat_reg;
    case (state_reg)
      IDLE: begin
        if (req_int && !mem_addr_ok) begin
          state_next     = HOLD;
          grant_lat_next = grant_sel;
        end
      end
      HOLD: begin
        if (accept || !granted_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_slot_we
      assign slot_we[gi] = accept & (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      grant_lat_reg <= 1'b0;
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= 4'd0;
      proto_err_reg <= 1'b0;
      owner_reg     <= '0;
    end else begin
      state_reg     <= state_next;
      grant_lat_reg <= grant_lat_next;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (slot_we[i]) owner_reg[i] <= grant_sel;
      end
      if (accept) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)    rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({accept, pop})
        2'b10:   count_reg <= count_reg + 4'd1;
        2'b01:   count_reg <= count_reg - 4'd1;
        default: count_reg <= count_reg;
      endcase
      if (mem_data_ok && fifo_empty) proto_err_reg <= 1'b1;
    end
  end

  // Every combinational output is forced low while reset is held, not just after the next edge.
  assign mem_req      = req_int;
  assign mem_wr       = resetn & (grant_sel ? data_wr : inst_wr);
  assign mem_size     = resetn ? (grant_sel ? data_size  : inst_size)  : 2'd0;
  assign mem_addr     = resetn ? (grant_sel ? data_addr  : inst_addr)  : '0;
  assign mem_wstrb    = resetn ? (grant_sel ? data_wstrb : inst_wstrb) : '0;
  assign mem_wdata    = resetn ? (grant_sel ? data_wdata : inst_wdata) : '0;

  assign inst_addr_ok = accept & ~grant_sel;
  assign data_addr_ok = accept & grant_sel;
  assign inst_data_ok = pop & ~head;
  assign data_data_ok = pop & head;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  assign outstanding  = count_reg;
  assign proto_err    = proto_err_reg;
endmodule
